// File: rtl/posit_pkg.sv
// posit_pkg: shared posit decode widths, log2 helper and decoded result type
package posit_pkg;
  function automatic int log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  localparam int PN = 16;
  localparam int PES = 2;
  localparam int PBS = log2(PN);
  localparam int SW = PBS + PES + 2;
  typedef struct packed {
    logic sign;
    logic zero;
    logic nar;
    logic [SW-1:0] scale;
    logic [PN-PES-1:0] frac;
  } posit_dec_t;
endpackage

// File: rtl/data_extract.sv
// data_extract: splits a positive posit magnitude (sign bit dropped) into regime, exponent and fraction
module data_extract import posit_pkg::*; #(
  parameter int N = PN,
  parameter int es = PES
) (
  input  logic [N-2:0]       mag_i,
  output logic               rc_o,
  output logic [log2(N)-1:0] regime_o,
  output logic [es-1:0]      exp_o,
  output logic [N-es-1:0]    frac_o
);
  localparam int BS = log2(N);
  logic [BS:0] m;
  logic run;
  logic [N-2:0] rem;
  // length of the run of bits equal to the first regime bit
  always_comb begin
    m = '0;
    run = 1'b1;
    for (int i = N-2; i >= 0; i--) begin
      run = run & (mag_i[i] == mag_i[N-2]);
      m = m + {{BS{1'b0}}, run};
    end
  end
  assign rem = mag_i << (m + 1'b1);
  assign rc_o = mag_i[N-2];
  assign regime_o = rc_o ? m[BS-1:0] - 1'b1 : m[BS-1:0];
  assign exp_o = rem[N-2 -: es];
  assign frac_o = {rem[N-2-es:0], 1'b0};
endmodule

// File: rtl/posit_decode_stage.sv
// posit_decode_stage: two-stage valid/ready posit unpacker producing sign, flags, scale and fraction
module posit_decode_stage import posit_pkg::*; #(
  parameter int N = PN,
  parameter int es = PES,
  parameter int TAG_W = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N-1:0]            in_data,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sign,
  output logic                    out_zero,
  output logic                    out_nar,
  output logic [log2(N)+es+1:0]   out_scale,
  output logic [N-es-1:0]         out_frac,
  output logic [TAG_W-1:0]        out_tag
);
  localparam int BS = log2(N);
  logic v1_q, v2_q, v1_d, v2_d, adv2, acc;
  logic sign1_q, zero1_q, nar1_q;
  logic [N-2:0] mag_q, mag_d;
  logic [TAG_W-1:0] tag1_q, tag2_q;
  posit_dec_t dec_q, dec_d;
  logic rc;
  logic [BS-1:0] regime;
  logic [es-1:0] ex;
  logic [N-es-1:0] frac;
  logic [SW-1:0] kv, k;
  assign adv2 = !v2_q || out_ready;
  assign in_ready = !v1_q || adv2;
  assign acc = in_valid && in_ready;
  assign v1_d = acc || (v1_q && !adv2);
  assign v2_d = adv2 ? v1_q : v2_q;
  assign mag_d = (in_data[N-2:0] ^ {(N-1){in_data[N-1]}}) + {{(N-2){1'b0}}, in_data[N-1]};
  data_extract #(.N(N), .es(es)) u_extract (
    .mag_i(mag_q),
    .rc_o(rc),
    .regime_o(regime),
    .exp_o(ex),
    .frac_o(frac)
  );
  // stage-2 decode: signed scale from regime and exponent, specials forced to zero scale/fraction
  always_comb begin
    kv = {{(SW-BS){1'b0}}, regime};
    k = rc ? kv : -kv;
    dec_d.sign = sign1_q;
    dec_d.zero = zero1_q;
    dec_d.nar = nar1_q;
    dec_d.scale = (zero1_q || nar1_q) ? '0 : (k << es) + {{(SW-es){1'b0}}, ex};
    dec_d.frac = (zero1_q || nar1_q) ? '0 : frac;
  end
  // pipeline registers: stage 1 loads on accept, stage 2 loads when it can advance
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      sign1_q <= 1'b0;
      zero1_q <= 1'b0;
      nar1_q <= 1'b0;
      mag_q <= '0;
      tag1_q <= '0;
      dec_q <= '0;
      tag2_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      if (acc) begin
        sign1_q <= in_data[N-1];
        zero1_q <= in_data == '0;
        nar1_q <= in_data == {1'b1, {(N-1){1'b0}}};
        mag_q <= mag_d;
        tag1_q <= in_tag;
      end
      if (adv2 && v1_q) begin
        dec_q <= dec_d;
        tag2_q <= tag1_q;
      end
    end
  end
  assign out_valid = v2_q;
  assign out_sign = dec_q.sign;
  assign out_zero = dec_q.zero;
  assign out_nar = dec_q.nar;
  assign out_scale = dec_q.scale;
  assign out_frac = dec_q.frac;
  assign out_tag = tag2_q;
endmodule

// File: tb/tb_posit_decode_stage.sv
// tb_posit_decode_stage: scoreboard bench with directed posit vectors, streaming, stall and reset
module tb_posit_decode_stage;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [15:0] in_data = '0;
  logic [7:0] in_tag = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic out_sign, out_zero, out_nar;
  logic [7:0] out_scale;
  logic [13:0] out_frac;
  logic [7:0] out_tag;
  int pass_cnt = 0;
  int tot_cnt = 0;
  logic [32:0] sb [$];
  logic [15:0] vd [16] = '{16'h4000, 16'h5000, 16'h7FFF, 16'h0001, 16'hC000, 16'h0000, 16'h8000, 16'h4800,
                           16'h4400, 16'hB000, 16'h3000, 16'h0002, 16'h7FFE, 16'h0003, 16'hFFFF, 16'h4123};
  // {sign, zero, nar, scale, frac}
  logic [24:0] ve [16] = '{
    {3'b000, 8'h00, 14'h0000}, {3'b000, 8'h02, 14'h0000}, {3'b000, 8'h38, 14'h0000}, {3'b000, 8'hC8, 14'h0000},
    {3'b100, 8'h00, 14'h0000}, {3'b010, 8'h00, 14'h0000}, {3'b101, 8'h00, 14'h0000}, {3'b000, 8'h01, 14'h0000},
    {3'b000, 8'h00, 14'h2000}, {3'b100, 8'h02, 14'h0000}, {3'b000, 8'hFE, 14'h0000}, {3'b000, 8'hCC, 14'h0000},
    {3'b000, 8'h34, 14'h0000}, {3'b000, 8'hCE, 14'h0000}, {3'b100, 8'hC8, 14'h0000}, {3'b000, 8'h00, 14'h0918}};

  posit_decode_stage dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_zero(out_zero), .out_nar(out_nar), .out_scale(out_scale),
    .out_frac(out_frac), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] got();
    return {out_sign, out_zero, out_nar, out_scale, out_frac, out_tag};
  endfunction

  task automatic chk(input string nm, input logic ok, input logic [63:0] a, input logic [63:0] r);
    tot_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got %h want %h", nm, a, r);
  endtask

  task automatic monitor();
    logic [32:0] held, e;
    logic stall;
    stall = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) stall = 1'b0;
      else begin
        if (stall) chk("stable", got() == held, got(), held);
        stall = out_valid && !out_ready;
        held = got();
        if (out_valid && out_ready) begin
          if (sb.size() == 0) chk("spurious", 1'b0, got(), 0);
          else begin
            e = sb.pop_front();
            chk("out", got() == e, got(), e);
          end
        end
      end
    end
  endtask

  task automatic send(input logic [15:0] d, input logic [7:0] t, input logic [24:0] e);
    int n;
    n = 0;
    in_data = d;
    in_tag = t;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) chk("accept_timeout", 1'b0, n, 100);
    else sb.push_back({e, t});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1 chk("drain", sb.size() == 0, sb.size(), 0);
  endtask

  initial begin
    fork
      monitor();
    join_none
    #1 chk("reset_valid", out_valid == 1'b0, out_valid, 0);
    chk("reset_data", got() == '0, got(), 0);
    chk("reset_ready", in_ready == 1'b1, in_ready, 1);
    #11 reset_n = 1'b1;
    @(posedge clk);
    #1;
    send(vd[0], 8'hA0, ve[0]);
    chk("latency_edge1", out_valid == 1'b0, out_valid, 0);
    @(posedge clk);
    #1 chk("latency_edge2", out_valid == 1'b1, out_valid, 1);
    drain();
    for (int i = 1; i < 16; i++) begin
      send(vd[i], 8'hA0 + 8'(i), ve[i]);
      drain();
    end
    for (int i = 0; i < 8; i++) send(vd[i], 8'h10 + 8'(i), ve[i]);
    drain();
    out_ready = 1'b0;
    send(vd[8], 8'h20, ve[8]);
    send(vd[9], 8'h21, ve[9]);
    chk("stall_in_ready", in_ready == 1'b0, in_ready, 0);
    fork
      send(vd[10], 8'h22, ve[10]);
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    send(vd[11], 8'h23, ve[11]);
    drain();
    out_ready = 1'b0;
    send(vd[12], 8'h30, ve[12]);
    send(vd[13], 8'h31, ve[13]);
    #2 sb.delete();
    reset_n = 1'b0;
    #1 chk("async_reset_valid", out_valid == 1'b0, out_valid, 0);
    chk("async_reset_data", got() == '0, got(), 0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(vd[1], 8'h40, ve[1]);
    drain();
    repeat (3) @(posedge clk);
    #1 chk("final_empty", sb.size() == 0 && out_valid == 1'b0, {sb.size(), out_valid}, 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
